// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces whole sweeps
// and reports one accepted key as a hex code. Optional auto-repeat: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    // state    | meaning
    // S_IDLE   | no candidate key
    // S_DEBNC  | candidate seen in cnt_q consecutive sweeps
    // S_PRESS  | key accepted and still detected
    // S_RELS   | accepted key missing for cnt_q consecutive sweeps
    typedef enum logic [1:0] {S_IDLE, S_DEBNC, S_PRESS, S_RELS} state_t;

    localparam int DW = $clog2(SCAN_TICKS);
    localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
    localparam logic [BW-1:0] DB_N       = BW'(DEBOUNCE_SCANS);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_SCANS - 1);

    if (SCAN_TICKS < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    function automatic logic [3:0] code_of(input logic [3:0] pos);
        case (pos)
            4'd0:  code_of = 4'h1;  4'd1:  code_of = 4'h2;
            4'd2:  code_of = 4'h3;  4'd3:  code_of = 4'hA;
            4'd4:  code_of = 4'h4;  4'd5:  code_of = 4'h5;
            4'd6:  code_of = 4'h6;  4'd7:  code_of = 4'hB;
            4'd8:  code_of = 4'h7;  4'd9:  code_of = 4'h8;
            4'd10: code_of = 4'h9;  4'd11: code_of = 4'hC;
            4'd12: code_of = 4'h0;  4'd13: code_of = 4'hF;
            4'd14: code_of = 4'hE;  default: code_of = 4'hD;
        endcase
    endfunction

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q;
    logic [3:0]    col_n_q;
    logic [15:0]   mat_q, snap_q;
    logic          sweep_end_q, eval_q;
    logic          dwell_end;

    always_comb begin
        dwell_end = (dwell_q == DWELL_LAST);
        dwell_d   = dwell_end ? '0 : dwell_q + 1'b1;
    end

    // Matrix bit {row, col}; the sweep is snapshotted so the next sweep can overwrite mat_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q     <= '0;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            mat_q       <= '0;
            snap_q      <= '0;
            sweep_end_q <= 1'b0;
            eval_q      <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            sweep_end_q <= 1'b0;
            eval_q      <= sweep_end_q;
            if (sweep_end_q) snap_q <= mat_q;
            if (dwell_end) begin
                col_q   <= col_q + 2'd1;
                col_n_q <= {col_n_q[2:0], col_n_q[3]};
                for (int r = 0; r < 4; r++) mat_q[{2'(r), col_q}] <= ~row_n[2'(r)];
                if (col_q == 2'd3) sweep_end_q <= 1'b1;
            end
        end
    end

    logic       single, cand_hit;
    logic [3:0] hit_pos;
    state_t     state_q;
    logic [3:0] cand_q, key_code_q;
    logic [BW-1:0] cnt_q;
    logic       key_valid_q, key_held_q;

    always_comb begin
        single  = ($countones(snap_q) == 1);
        hit_pos = 4'd0;
        for (int i = 0; i < 16; i++) if (snap_q[4'(i)]) hit_pos = 4'(i);
        cand_hit = snap_q[cand_q];
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (eval_q) begin
                case (state_q)
                    S_IDLE: if (single) begin
                        cand_q <= hit_pos;
                        cnt_q  <= BW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q     <= S_PRESS;
                            cnt_q       <= DB_N;
                            key_code_q  <= code_of(hit_pos);
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_q       <= '0;
`endif
                        end else begin
                            state_q <= S_DEBNC;
                        end
                    end
                    S_DEBNC: if (single && hit_pos == cand_q) begin
                        if (cnt_q == DB_LAST) begin
                            state_q     <= S_PRESS;
                            cnt_q       <= DB_N;
                            key_code_q  <= code_of(cand_q);
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_q       <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (single) begin
                        cand_q <= hit_pos;
                        cnt_q  <= BW'(1);
                    end else begin
                        state_q <= S_IDLE;
                    end
                    S_PRESS: if (cand_hit) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_q == RW'(REPEAT_SCANS - 1)) begin
                            rep_q       <= '0;
                            key_valid_q <= 1'b1;
                        end else begin
                            rep_q <= rep_q + 1'b1;
                        end
`endif
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_q    <= S_IDLE;
                        key_held_q <= 1'b0;
                    end else begin
                        state_q <= S_RELS;
                        cnt_q   <= BW'(1);
                    end
                    default: if (cand_hit) begin
                        state_q <= S_PRESS;
                    end else if (cnt_q == DB_LAST) begin
                        state_q    <= S_IDLE;
                        cnt_q      <= DB_N;
                        key_held_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                endcase
            end
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key sets, checked cycle by cycle
// against a sweep-level model of the keypad behaviour.
module tb_keypad_scanner;
    localparam int ST = 4;
    localparam int DB = 3;
    localparam int RS = 5;
    localparam int SW = 4 * ST;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] row_n, col_n, key_code;
    logic key_valid, key_held;
    logic [15:0] keys;

    always #5 clk = ~clk;

    // Ideal keypad: bit {row, col} pressed pulls row low while that column is driven.
    assign row_n = {~|(keys[15:12] & ~col_n), ~|(keys[11:8] & ~col_n),
                    ~|(keys[7:4] & ~col_n),   ~|(keys[3:0] & ~col_n)};

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RS)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held));

    int checks = 0;
    int failures = 0;

    logic [3:0] keymap [16];
    int         m_state, m_cnt, m_rep;
    logic [3:0] m_cand;
    logic [3:0] exp_code, pend_code;
    logic       exp_held, pend_held, exp_valid, pend_pulse;

    task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_rep = 0; m_cand = 4'd0;
        exp_code = 4'h0; exp_held = 1'b0; exp_valid = 1'b0;
        pend_code = 4'h0; pend_held = 1'b0; pend_pulse = 1'b0;
    endtask

    task automatic model_accept();
        m_state = 2; m_rep = 0;
        pend_code = keymap[m_cand];
        pend_pulse = 1'b1;
    endtask

    // One full sweep with key set k; effects become visible 2 cycles into the next sweep.
    task automatic model_sweep(input logic [15:0] k);
        int n;
        logic [3:0] p;
        logic hit;
        n = $countones(k);
        p = 4'd0;
        for (int i = 0; i < 16; i++) if (k[4'(i)]) p = 4'(i);
        hit = k[m_cand];
        pend_pulse = 1'b0;
        case (m_state)
            0: if (n == 1) begin
                m_cand = p; m_cnt = 1;
                if (DB == 1) model_accept(); else m_state = 1;
            end
            1: if (n == 1 && p == m_cand) begin
                m_cnt++;
                if (m_cnt == DB) model_accept();
            end else if (n == 1) begin
                m_cand = p; m_cnt = 1;
            end else begin
                m_state = 0;
            end
            2: if (hit) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                m_rep++;
                if (m_rep == RS) begin m_rep = 0; pend_pulse = 1'b1; end
`endif
            end else begin
                m_state = 3; m_cnt = 1;
                if (m_cnt >= DB) m_state = 0;
            end
            default: if (hit) begin
                m_state = 2;
            end else begin
                m_cnt++;
                if (m_cnt >= DB) m_state = 0;
            end
        endcase
        pend_held = (m_state == 2 || m_state == 3);
    endtask

    task automatic run_cycles(input logic [15:0] k, input int n, input bit eval);
        logic [3:0] cp;
        keys = k;
        for (int off = 0; off < n; off++) begin
            if (off == 2) begin
                exp_code = pend_code; exp_held = pend_held; exp_valid = pend_pulse;
            end else begin
                exp_valid = 1'b0;
            end
            cp = ~(4'b0001 << (off / ST));
            check1("col_n", col_n, cp);
            check1("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
            check1("key_held", {3'b000, key_held}, {3'b000, exp_held});
            check1("key_code", key_code, exp_code);
            @(posedge clk); #1;
        end
        if (eval) model_sweep(k);
    endtask

    task automatic sweeps(input logic [15:0] k, input int count);
        for (int s = 0; s < count; s++) run_cycles(k, SW, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        kbit = 16'b1 << (r * 4 + c);
    endfunction

    initial begin
        logic [15:0] k;
        int sel;
        keymap[0] = 4'h1;  keymap[1] = 4'h2;  keymap[2] = 4'h3;  keymap[3] = 4'hA;
        keymap[4] = 4'h4;  keymap[5] = 4'h5;  keymap[6] = 4'h6;  keymap[7] = 4'hB;
        keymap[8] = 4'h7;  keymap[9] = 4'h8;  keymap[10] = 4'h9; keymap[11] = 4'hC;
        keymap[12] = 4'h0; keymap[13] = 4'hF; keymap[14] = 4'hE; keymap[15] = 4'hD;
        keys = 16'h0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // idle scanning
        sweeps(16'h0000, 13);
        // R2C3 held 10 sweeps, then released
        sweeps(kbit(1, 2), 10);
        sweeps(16'h0000, 5);
        // R4C4 bounce, then a real press
        sweeps(kbit(3, 3), 2);
        sweeps(16'h0000, 1);
        sweeps(kbit(3, 3), 5);
        sweeps(16'h0000, 4);
        // R1C1 + R3C2, then R1C1 alone, then R1C4 added
        sweeps(kbit(0, 0) | kbit(2, 1), 3);
        sweeps(kbit(0, 0), 4);
        sweeps(kbit(0, 0) | kbit(0, 3), 3);
        sweeps(16'h0000, 4);
        // reset during debounce of R4C1
        sweeps(kbit(3, 0), 2);
        run_cycles(kbit(3, 0), 7, 1'b0);
        do_reset();
        sweeps(kbit(3, 0), 5);
        sweeps(16'h0000, 4);
        // long hold of R3C4 (repeat pulses when auto-repeat is built)
        sweeps(kbit(2, 3), 23);
        sweeps(16'h0000, 4);

        // random key sets and hold lengths, occasional mid-sweep reset
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) k = 16'h0000;
            else if (sel < 8) k = 16'b1 << $urandom_range(0, 15);
            else if (sel == 8) k = (16'b1 << $urandom_range(0, 15)) | (16'b1 << $urandom_range(0, 15));
            else k = keys | (16'b1 << $urandom_range(0, 15));
            sweeps(k, $urandom_range(1, 6));
            if ($urandom_range(0, 15) == 0) begin
                run_cycles(k, $urandom_range(1, 15), 1'b0);
                do_reset();
            end
        end
        sweeps(16'h0000, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
